x_window_buffer: RTL
====================

X_WINDOW_BUFFER -- requirements
Module: x_window_buffer

Interface
REQ-001 Parameter WIDTH, default 16: signed word width in bits.
REQ-002 Parameter SIZE, default 64: window depth in words.
REQ-003 Parameter LOGSIZE, default 6: equals ceil(log2(SIZE)).
REQ-004 Parameter LANES, default 1: words accepted per input beat; SIZE SHALL be a multiple of LANES.
REQ-005 Parameter STRIDE, default 1: words retired per window consume; LANES <= STRIDE <= SIZE.
REQ-006 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-008 Port clear  input  1  synchronous flush of window occupancy.
REQ-009 Port s_valid  input  1  input beat offered.
REQ-010 Port s_ready  output  1  input beat can be accepted this cycle.
REQ-011 Port s_data  input  LANES x WIDTH signed  beat words; lane 0 is the oldest.
REQ-012 Port win_valid  output  1  full window available on data_out.
REQ-013 Port win_ready  input  1  consumer retires STRIDE words this cycle.
REQ-014 Port data_out  output  SIZE x WIDTH signed  parallel window; index 0 is the oldest word.
REQ-015 Port count  output  LOGSIZE+1  number of valid words currently held (0..SIZE).

Function
REQ-016 Storage SHALL be SIZE registers mem[0..SIZE-1]; data_out SHALL be driven directly from mem with no added latency.
REQ-017 Accept = s_valid && s_ready; on accept, mem[i] <= mem[i+LANES] for i < SIZE-LANES, and mem[SIZE-LANES+k] <= s_data[k] for k = 0..LANES-1.
REQ-018 Without an accept, mem SHALL hold its value.
REQ-019 win_valid SHALL be 1 exactly when count == SIZE; it is a registered-state decode with no combinational path from inputs.
REQ-020 Consume = win_valid && win_ready; consume SHALL NOT move mem contents, and SHALL reduce count by STRIDE.
REQ-021 s_ready SHALL be (count <= SIZE-LANES) || consume; the win_ready-to-s_ready combinational path is intentional and documented.
REQ-022 count_next: accept only -> count+LANES; consume only -> count-STRIDE; both -> count-STRIDE+LANES; neither -> count.
REQ-023 count SHALL never exceed SIZE and never go below 0 under legal parameters; s_valid with s_ready=0 SHALL have no effect (beat is held by the source).
REQ-024 win_ready while win_valid=0 SHALL be ignored.
REQ-025 clear SHALL set count to 0 on the next edge, overriding any same-cycle accept and consume; mem SHALL be left unchanged.
REQ-026 With STRIDE=SIZE (block mode), every window is disjoint; with STRIDE<SIZE (sliding mode), successive windows overlap by SIZE-STRIDE words.
REQ-027 Throughput: with LANES=STRIDE and win_ready tied high, one beat SHALL be accepted every cycle and win_valid SHALL assert every cycle once the window is first full.

Reset
REQ-028 While reset_n=0, all mem words SHALL be 0 and count SHALL be 0, asynchronously.
REQ-029 After reset, win_valid=0 and s_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all held words; the first window after deassertion SHALL need SIZE fresh words.
REQ-031 Deassertion SHALL be sampled synchronously to clk by the integrating design; the block needs no internal synchronizer.

Verification
REQ-032 SIZE=4, LANES=1, STRIDE=1: push 1,2,3,4 with win_ready=0 -> win_valid rises after the 4th edge, data_out={1,2,3,4} (index 0 = 1), s_ready=0, count=4.
REQ-033 Same state, offer 5 with win_ready=1 -> accept and consume in one cycle, data_out={2,3,4,5}, count stays 4, win_valid stays 1.
REQ-034 SIZE=4, LANES=2, STRIDE=4: push beats {1,2},{3,4} -> window {1,2,3,4}; consume -> count=0, win_valid=0, s_ready=1, data_out unchanged.
REQ-035 Full window plus clear=1 with s_valid=1 and win_ready=1 -> count=0, mem unchanged, no word accepted.
REQ-036 Pull reset_n low between clock edges with count=3 -> count=0 and data_out all 0 immediately, without a clock edge.
REQ-037 Random s_valid/win_ready stress against a reference queue model -> data_out and count match every cycle, count stays within 0..SIZE.

Source files
------------

// File: rtl/x_window_buffer_if.sv
// -----------------------------------------------------------------------------
// x_window_buffer_if
//
// Purpose: groups the streaming input handshake and the window output bus of
//          x_window_buffer. clk, reset_n and clear are plain ports on the
//          block and are not carried here.
//
// Signals:
//   s_valid    source -> buffer  input beat offered
//   s_ready    buffer -> source  beat can be accepted this cycle
//   s_data     source -> buffer  LANES signed words, lane 0 is the oldest
//   win_valid  buffer -> sink    full window available on data_out
//   win_ready  sink   -> buffer  sink retires STRIDE words this cycle
//   data_out   buffer -> sink    SIZE signed words, index 0 is the oldest
//   count      buffer -> sink    number of valid words held (0..SIZE)
//
// Modports:
//   slave  - the buffer side (used by x_window_buffer)
//   master - the producer/consumer side driving the buffer
// -----------------------------------------------------------------------------
interface x_window_buffer_if #(
  parameter int WIDTH   = 16,
  parameter int SIZE    = 64,
  parameter int LOGSIZE = 6,
  parameter int LANES   = 1
);

  logic                      s_valid;
  logic                      s_ready;
  logic signed [WIDTH-1:0]   s_data   [LANES];
  logic                      win_valid;
  logic                      win_ready;
  logic signed [WIDTH-1:0]   data_out [SIZE];
  logic        [LOGSIZE:0]   count;

  modport slave (
    input  s_valid,
    output s_ready,
    input  s_data,
    output win_valid,
    input  win_ready,
    output data_out,
    output count
  );

  modport master (
    output s_valid,
    input  s_ready,
    output s_data,
    input  win_valid,
    output win_ready,
    input  data_out,
    input  count
  );

endinterface

// File: rtl/x_window_buffer.sv
// -----------------------------------------------------------------------------
// x_window_buffer
//
// Purpose: sliding / block window buffer. Words stream in LANES at a time and
//          shift through a SIZE-deep register window; when the window is full
//          the consumer may retire STRIDE words at once. Retiring only lowers
//          the occupancy count -- the window contents never move on consume,
//          so the next window is simply the current one shifted by the next
//          STRIDE words that arrive.
//
// Parameters:
//   WIDTH    signed word width in bits
//   SIZE     window depth in words
//   LOGSIZE  ceil(log2(SIZE))
//   LANES    words accepted per input beat (SIZE must be a multiple of LANES)
//   STRIDE   words retired per consume (LANES <= STRIDE <= SIZE)
//
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset (clears mem and count)
//   clear    synchronous flush of occupancy; mem is left untouched
//   bus      x_window_buffer_if.slave: s_valid/s_ready/s_data input stream,
//            win_valid/win_ready/data_out window output, count occupancy
// -----------------------------------------------------------------------------
module x_window_buffer #(
  parameter int WIDTH   = 16,
  parameter int SIZE    = 64,
  parameter int LOGSIZE = 6,
  parameter int LANES   = 1,
  parameter int STRIDE  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  x_window_buffer_if.slave      bus
);

  localparam int CW = LOGSIZE + 1;

  localparam logic [CW-1:0] SIZE_W    = CW'(SIZE);
  localparam logic [CW-1:0] LANES_W   = CW'(LANES);
  localparam logic [CW-1:0] STRIDE_W  = CW'(STRIDE);
  // Highest occupancy at which a full beat still fits without a consume.
  localparam logic [CW-1:0] ROOM_W    = CW'(SIZE - LANES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] mem_q [SIZE];
  logic signed [WIDTH-1:0] mem_d [SIZE];
  logic        [CW-1:0]    count_q;
  logic        [CW-1:0]    count_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic win_valid;
  logic consume;
  logic s_ready;
  logic accept;
  logic write_en;

  // win_valid is a pure decode of registered count: no input reaches it.
  assign win_valid = (count_q == SIZE_W);
  assign consume   = win_valid && bus.win_ready;

  // A consume frees STRIDE >= LANES words, so a beat can be taken in the same
  // cycle even when the window is full. This makes win_ready -> s_ready a
  // deliberate combinational path; the consumer must not derive win_ready
  // from s_ready.
  assign s_ready   = (count_q <= ROOM_W) || consume;
  assign accept    = bus.s_valid && s_ready;

  // clear wins over a same-cycle accept: the offered beat is dropped and the
  // window contents stay exactly as they were.
  assign write_en  = accept && !clear;

  // ---------------------------------------------------------------------------
  // Next-state: window shift
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (write_en) begin
      // Older words move down by one beat; the new beat lands at the top with
      // lane 0 (oldest of the beat) at the lowest of the top slots.
      for (int i = 0; i < SIZE - LANES; i++) begin
        mem_d[i] = mem_q[i + LANES];
      end
      for (int k = 0; k < LANES; k++) begin
        mem_d[SIZE - LANES + k] = bus.s_data[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      unique case ({accept, consume})
        2'b10:   count_d = count_q + LANES_W;
        2'b01:   count_d = count_q - STRIDE_W;
        // consume only happens at count == SIZE, so the subtraction first
        // cannot wrap and the result stays within 0..SIZE.
        2'b11:   count_d = count_q - STRIDE_W + LANES_W;
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SIZE; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        mem_q[i] <= mem_d[i];
      end
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: the window is presented straight from the registers.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_out
      assign bus.data_out[gi] = mem_q[gi];
    end
  endgenerate

  assign bus.win_valid = win_valid;
  assign bus.s_ready   = s_ready;
  assign bus.count     = count_q;

endmodule
